// File: rtl/wb_trace_buffer.sv
// Circular trace of committed write-backs {pc, reg, data}, stepped oldest->newest for display.
// Latency: capture on the wb_ack rising-edge cycle; trace_* registered one cycle after state change.
// Backpressure: none; wb_ack is never gated, and commits seen while frozen are only counted.
module wb_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_ack,
    input  logic [1:0]       wb_addr,
    input  logic [3:0]       wb_data,
    input  logic [7:0]       wb_pc,
    input  logic             freeze,
    input  logic             rd_step,
    input  logic             clear,
    output logic [7:0]       trace_pc,
    output logic [1:0]       trace_reg,
    output logic [3:0]       trace_data,
    output logic [PTR_W-1:0] trace_idx,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [3:0]       dropped
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

    logic [13:0]      mem [DEPTH];
    logic             ack_q;
    logic             step_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] oldest_ptr;
    logic [PTR_W-1:0] idx_q;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic [3:0]       dropped_q;
    logic [13:0]      trace_q;

    logic             cap;
    logic             step_ev;
    logic             wr_en;
    logic [PTR_W-1:0] view_ptr;
    logic [PTR_W:0]   last_idx;

    assign cap      = wb_ack & ~ack_q;
    assign step_ev  = rd_step & ~step_q;
    assign wr_en    = cap & ~freeze & ~clear & ~rst;
    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign view_ptr = oldest_ptr + idx_q;
    assign last_idx = count_q - ONE_C;

    // Edge history survives clear so a held wb_ack/rd_step is not re-detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            ack_q  <= wb_ack;
            step_q <= rd_step;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {wb_pc, wb_addr, wb_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr     <= '0;
            oldest_ptr <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            trace_q    <= '0;
        end else begin
            if (cap) begin
                if (freeze) begin
                    if (dropped_q != 4'hF) begin
                        dropped_q <= dropped_q + 4'd1;
                    end
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (count_q == DEPTH_C) begin
                        oldest_ptr <= oldest_ptr + 1'b1;
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + ONE_C;
                    end
                end
            end
            // Wrap test uses the pre-capture count; an overwrite shifts the window under idx_q.
            if (step_ev && count_q != '0) begin
                idx_q <= ({1'b0, idx_q} == last_idx) ? '0 : idx_q + 1'b1;
            end
            trace_q <= (count_q == '0) ? '0 : mem[view_ptr];
        end
    end

    assign trace_pc   = trace_q[13:6];
    assign trace_reg  = trace_q[5:4];
    assign trace_data = trace_q[3:0];
    assign trace_idx  = idx_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign overflow   = overflow_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed scenarios then random traffic against a queue-based reference model.
module tb_wb_trace_buffer;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wb_ack = 1'b0;
    logic [1:0]       wb_addr = '0;
    logic [3:0]       wb_data = '0;
    logic [7:0]       wb_pc = '0;
    logic             freeze = 1'b0;
    logic             rd_step = 1'b0;
    logic             clear = 1'b0;
    logic [7:0]       trace_pc;
    logic [1:0]       trace_reg;
    logic [3:0]       trace_data;
    logic [PTR_W-1:0] trace_idx;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic [3:0]       dropped;

    wb_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .wb_ack(wb_ack), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_pc(wb_pc), .freeze(freeze), .rd_step(rd_step), .clear(clear),
        .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
        .trace_idx(trace_idx), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the buffer as an ordered list, oldest first.
    logic [13:0] q[$];
    int          m_idx  = 0;
    bit          m_ov   = 1'b0;
    int          m_drop = 0;
    bit          m_pack = 1'b0;
    bit          m_pstp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic [13:0] exp_tr;
        bit          cap;
        bit          stp;
        exp_tr = (q.size() == 0) ? 14'h0 : q[m_idx];
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_idx = 0; m_ov = 1'b0; m_drop = 0; m_pack = 1'b0; m_pstp = 1'b0;
            exp_tr = 14'h0;
        end else begin
            cap    = wb_ack && !m_pack;
            stp    = rd_step && !m_pstp;
            m_pack = wb_ack;
            m_pstp = rd_step;
            if (clear) begin
                q.delete();
                m_idx = 0; m_ov = 1'b0; m_drop = 0;
                exp_tr = 14'h0;
            end else begin
                if (stp && q.size() > 0) begin
                    m_idx = (m_idx == q.size() - 1) ? 0 : m_idx + 1;
                end
                if (cap) begin
                    if (freeze) begin
                        if (m_drop < 15) m_drop++;
                    end else begin
                        q.push_back({wb_pc, wb_addr, wb_data});
                        if (q.size() > DEPTH) begin
                            void'(q.pop_front());
                            m_ov = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
        check("count",     32'(count),     32'(q.size()));
        check("empty",     32'(empty),     32'(q.size() == 0));
        check("full",      32'(full),      32'(q.size() == DEPTH));
        check("overflow",  32'(overflow),  32'(m_ov));
        check("dropped",   32'(dropped),   32'(m_drop));
        check("trace_idx", 32'(trace_idx), 32'(m_idx));
        check("trace",     32'({trace_pc, trace_reg, trace_data}), 32'(exp_tr));
    endtask

    task automatic commit(input logic [7:0] pc, input logic [1:0] r, input logic [3:0] d);
        wb_pc = pc; wb_addr = r; wb_data = d;
        wb_ack = 1'b1; tick();
        wb_ack = 1'b0; tick();
    endtask

    task automatic step();
        rd_step = 1'b1; tick();
        rd_step = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
    endtask

    initial begin
        do_reset();
        check("rst_trace_pc", 32'(trace_pc), 32'h0);
        check("rst_empty",    32'(empty),    32'h1);

        // Three commits, step through, wrap.
        commit(8'h01, 2'd1, 4'h5);
        commit(8'h02, 2'd2, 4'hA);
        commit(8'h03, 2'd3, 4'hF);
        check("three_count", 32'(count), 32'd3);
        check("three_view0", 32'({trace_pc, trace_reg, trace_data}), 32'({8'h01, 2'd1, 4'h5}));
        step(); step();
        check("three_view2", 32'({trace_pc, trace_reg, trace_data}), 32'({8'h03, 2'd3, 4'hF}));
        step();
        check("three_wrap", 32'(trace_idx), 32'd0);

        // Held wb_ack gives one capture.
        do_reset();
        wb_pc = 8'h44; wb_addr = 2'd2; wb_data = 4'h7; wb_ack = 1'b1;
        repeat (5) tick();
        wb_ack = 1'b0; tick();
        check("held_ack_count", 32'(count), 32'd1);

        // Overflow: 10 commits into 8 entries.
        do_reset();
        for (int i = 0; i < 10; i++) commit(8'(8'h10 + i), 2'(i), 4'(i));
        check("ovf_full",     32'(full),     32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_oldest",   32'(trace_pc), 32'h12);

        // Simultaneous capture and step while full at trace_idx 3.
        repeat (3) step();
        wb_pc = 8'h77; wb_addr = 2'd1; wb_data = 4'h3;
        wb_ack = 1'b1; rd_step = 1'b1; tick();
        wb_ack = 1'b0; rd_step = 1'b0; tick();
        check("simul_idx",  32'(trace_idx), 32'd4);
        check("simul_view", 32'(trace_pc),  32'h17);

        // Freeze saturates dropped, then normal capture resumes.
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) commit(8'hEE, 2'd0, 4'h0);
        check("freeze_drop", 32'(dropped), 32'd15);
        freeze = 1'b0;
        commit(8'h99, 2'd3, 4'h9);

        // Clear with a coincident commit; next commit lands at index 0.
        wb_pc = 8'hAB; wb_ack = 1'b1; clear = 1'b1; tick();
        wb_ack = 1'b0; clear = 1'b0; tick();
        check("clear_count",   32'(count),    32'd0);
        check("clear_dropped", 32'(dropped),  32'd0);
        commit(8'h5C, 2'd2, 4'h6);
        tick();
        check("clear_next", 32'({trace_idx, trace_pc}), 32'({3'd0, 8'h5C}));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            wb_ack  = ($urandom_range(0, 99) < 45);
            wb_pc   = 8'($urandom);
            wb_addr = 2'($urandom);
            wb_data = 4'($urandom);
            freeze  = ($urandom_range(0, 99) < 10);
            rd_step = ($urandom_range(0, 99) < 35);
            clear   = ($urandom_range(0, 199) < 3);
            rst     = ($urandom_range(0, 399) < 2);
            tick();
        end
        rst = 1'b0; clear = 1'b0; wb_ack = 1'b0; rd_step = 1'b0; freeze = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
